// File: rtl/lcd_ctrl_if.sv
// LSU <-> LCD controller bundle: LCD command register in, physical LCD pins and
// polling status out. The master is the LSU/register side, the slave is lcd_ctrl.
interface lcd_ctrl_if;
  logic [31:0] i_lcd;
  logic [7:0]  o_lcd_data;
  logic        o_lcd_rs;
  logic        o_lcd_rw;
  logic        o_lcd_en;
  logic        o_lcd_on;
  logic        o_busy;
  logic [31:0] o_status;

  modport master (
    output i_lcd,
    input  o_lcd_data, o_lcd_rs, o_lcd_rw, o_lcd_en, o_lcd_on, o_busy, o_status
  );

  modport slave (
    input  i_lcd,
    output o_lcd_data, o_lcd_rs, o_lcd_rw, o_lcd_en, o_lcd_on, o_busy, o_status
  );
endinterface

// File: rtl/lcd_ctrl.sv
// HD44780-style write sequencer: turns a toggled LCD command word into a timed
// setup / enable / hold / execute cycle and reports busy plus the last acked toggle.
module lcd_ctrl #(
  parameter int POWERUP_CYC   = 750000,
  parameter int SETUP_CYC     = 2,
  parameter int PULSE_CYC     = 25,
  parameter int HOLD_CYC      = 2,
  parameter int EXEC_CYC      = 2000,
  parameter int LONG_EXEC_CYC = 82000
) (
  input logic         i_clk,
  input logic         i_reset,
  lcd_ctrl_if.slave   bus
);

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  localparam int MAX_CYC = max2(max2(max2(POWERUP_CYC, SETUP_CYC), max2(PULSE_CYC, HOLD_CYC)),
                                max2(EXEC_CYC, LONG_EXEC_CYC));
  localparam int CW = $clog2(MAX_CYC) + 1;

  localparam logic [CW-1:0] POWERUP_M1 = CW'(POWERUP_CYC - 1);
  localparam logic [CW-1:0] SETUP_M1   = CW'(SETUP_CYC - 1);
  localparam logic [CW-1:0] PULSE_M1   = CW'(PULSE_CYC - 1);
  localparam logic [CW-1:0] HOLD_M1    = CW'(HOLD_CYC - 1);
  localparam logic [CW-1:0] EXEC_M1    = CW'(EXEC_CYC - 1);
  localparam logic [CW-1:0] LONG_M1    = CW'(LONG_EXEC_CYC - 1);

  typedef enum logic [2:0] {
    S_INIT, S_IDLE, S_SETUP, S_PULSE, S_HOLD, S_WAIT
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          ack_q, ack_d;
  logic          req_q, req_d;
  logic          busy_q, busy_d;
  logic          en_q, en_d;
  logic          rs_q, rs_d;
  logic [7:0]    data_q, data_d;
  logic          on_q, on_d;

  logic [CW-1:0] limit_m1;
  logic          last;
  logic          is_long;
  logic          pending;

  // Clear (0x01) and home (0x02/0x03) need the long execution time.
  assign is_long = !rs_q && (data_q[7:2] == 6'd0) && (data_q[1:0] != 2'b00);
  assign pending = bus.i_lcd[10] != ack_q;

  always_comb begin
    limit_m1 = '0;
    unique case (state_q)
      S_INIT:  limit_m1 = POWERUP_M1;
      S_SETUP: limit_m1 = SETUP_M1;
      S_PULSE: limit_m1 = PULSE_M1;
      S_HOLD:  limit_m1 = HOLD_M1;
      S_WAIT:  limit_m1 = is_long ? LONG_M1 : EXEC_M1;
      default: limit_m1 = '0;
    endcase
  end

  assign last = (cnt_q == limit_m1);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + CW'(1);
    ack_d   = ack_q;
    req_d   = req_q;
    busy_d  = busy_q;
    en_d    = en_q;
    rs_d    = rs_q;
    data_d  = data_q;
    on_d    = bus.i_lcd[31];

    unique case (state_q)
      S_INIT: begin
        if (last) begin
          state_d = S_IDLE;
          busy_d  = 1'b0;
          cnt_d   = '0;
        end
      end
      S_IDLE: begin
        cnt_d  = '0;
        busy_d = 1'b0;
        if (pending) begin
          rs_d    = bus.i_lcd[9];
          data_d  = bus.i_lcd[7:0];
          req_d   = bus.i_lcd[10];
          busy_d  = 1'b1;
          state_d = S_SETUP;
        end
      end
      S_SETUP: begin
        if (last) begin
          state_d = S_PULSE;
          en_d    = 1'b1;
          cnt_d   = '0;
        end
      end
      S_PULSE: begin
        if (last) begin
          state_d = S_HOLD;
          en_d    = 1'b0;
          cnt_d   = '0;
        end
      end
      S_HOLD: begin
        if (last) begin
          state_d = S_WAIT;
          cnt_d   = '0;
        end
      end
      S_WAIT: begin
        if (last) begin
          state_d = S_IDLE;
          ack_d   = req_q;
          busy_d  = 1'b0;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = S_INIT;
        busy_d  = 1'b1;
        en_d    = 1'b0;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q <= S_INIT;
      cnt_q   <= '0;
      ack_q   <= 1'b0;
      req_q   <= 1'b0;
      busy_q  <= 1'b1;
      en_q    <= 1'b0;
      rs_q    <= 1'b0;
      data_q  <= 8'h00;
      on_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ack_q   <= ack_d;
      req_q   <= req_d;
      busy_q  <= busy_d;
      en_q    <= en_d;
      rs_q    <= rs_d;
      data_q  <= data_d;
      on_q    <= on_d;
    end
  end

  logic unused_lcd_bits;
  assign unused_lcd_bits = ^{bus.i_lcd[30:11], bus.i_lcd[8]};

  assign bus.o_lcd_data = data_q;
  assign bus.o_lcd_rs   = rs_q;
  assign bus.o_lcd_rw   = 1'b0;
  assign bus.o_lcd_en   = en_q;
  assign bus.o_lcd_on   = on_q;
  assign bus.o_busy     = busy_q;
  assign bus.o_status   = {30'b0, busy_q, ack_q};

endmodule

// File: tb/tb_lcd_ctrl.sv
// Directed bench for lcd_ctrl with shortened timing (POWERUP=10, SETUP=2,
// PULSE=3, HOLD=2, EXEC=5, LONG=20), so a normal write is busy 12 cycles, clear/home 27.
module tb_lcd_ctrl;
  logic i_clk = 1'b0;
  logic i_reset = 1'b1;
  int checks = 0;
  int errors = 0;

  always #5 i_clk = ~i_clk;

  lcd_ctrl_if bus ();

  lcd_ctrl #(
    .POWERUP_CYC(10), .SETUP_CYC(2), .PULSE_CYC(3),
    .HOLD_CYC(2), .EXEC_CYC(5), .LONG_EXEC_CYC(20)
  ) dut (
    .i_clk  (i_clk),
    .i_reset(i_reset),
    .bus    (bus)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step;
    @(posedge i_clk);
    #1;
  endtask

  task automatic start(input logic rs, input logic [7:0] d);
    bus.i_lcd[9]   = rs;
    bus.i_lcd[7:0] = d;
    bus.i_lcd[10]  = ~bus.i_lcd[10];
  endtask

  // mode 0: plain, 1: data change + double toggle, 2: single toggle, 3: power on in WAIT
  task automatic measure(input string tag, input int exp_len, input logic exp_rs,
                         input logic [7:0] exp_data, input int mode);
    int n;
    n = 0;
    step;
    while (bus.o_busy === 1'b1 && n < 200) begin
      n++;
      chk({tag, " en"},   32'(bus.o_lcd_en),   32'(n >= 3 && n <= 5));
      chk({tag, " rs"},   32'(bus.o_lcd_rs),   32'(exp_rs));
      chk({tag, " data"}, 32'(bus.o_lcd_data), 32'(exp_data));
      if ((mode == 1 || mode == 2) && n == 4) begin
        bus.i_lcd[7:0] = 8'hFF;
        bus.i_lcd[9]   = 1'b0;
        bus.i_lcd[10]  = ~bus.i_lcd[10];
      end
      if (mode == 1 && n == 6) bus.i_lcd[10] = ~bus.i_lcd[10];
      if (mode == 3 && n == 9) begin
        chk({tag, " on_before"}, 32'(bus.o_lcd_on), 32'd0);
        bus.i_lcd[31] = 1'b1;
      end
      if (mode == 3 && n == 10) chk({tag, " on_after"}, 32'(bus.o_lcd_on), 32'd1);
      step;
    end
    chk({tag, " busy_len"}, 32'(n), 32'(exp_len));
    $display("txn %s: busy %0d cycles, status 0x%0h", tag, n, bus.o_status);
  endtask

  task automatic init_wait(input string tag);
    for (int i = 1; i <= 9; i++) begin
      step;
      chk({tag, " busy"}, 32'(bus.o_busy), 32'd1);
      chk({tag, " en"},   32'(bus.o_lcd_en), 32'd0);
    end
    step;
    chk({tag, " idle"}, 32'(bus.o_busy), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.i_lcd = 32'h0;
    i_reset = 1'b1;
    step;
    step;
    chk("rst busy",   32'(bus.o_busy),     32'd1);
    chk("rst en",     32'(bus.o_lcd_en),   32'd0);
    chk("rst data",   32'(bus.o_lcd_data), 32'd0);
    chk("rst rs",     32'(bus.o_lcd_rs),   32'd0);
    chk("rst rw",     32'(bus.o_lcd_rw),   32'd0);
    chk("rst on",     32'(bus.o_lcd_on),   32'd0);
    chk("rst status", bus.o_status,        32'h2);

    // Request posted during power-up must wait for INIT to finish
    i_reset = 1'b0;
    step;
    step;
    start(1'b0, 8'h41);
    for (int i = 3; i <= 9; i++) begin
      step;
      chk("init busy", 32'(bus.o_busy), 32'd1);
    end
    step;
    chk("init idle", 32'(bus.o_busy), 32'd0);
    chk("init status", bus.o_status, 32'h0);
    measure("pwrup", 12, 1'b0, 8'h41, 0);
    chk("pwrup status", bus.o_status, 32'h1);

    start(1'b1, 8'h48);
    measure("data", 12, 1'b1, 8'h48, 0);
    chk("data status", bus.o_status, 32'h0);

    start(1'b0, 8'h01);
    measure("clear", 27, 1'b0, 8'h01, 0);
    chk("clear status", bus.o_status, 32'h1);

    start(1'b0, 8'h04);
    measure("entry", 12, 1'b0, 8'h04, 0);
    chk("entry status", bus.o_status, 32'h0);

    start(1'b0, 8'h02);
    measure("home", 27, 1'b0, 8'h02, 0);
    chk("home status", bus.o_status, 32'h1);

    // Double toggle while busy cancels out: no follow-up transaction
    start(1'b1, 8'h55);
    measure("dbl", 12, 1'b1, 8'h55, 1);
    chk("dbl status", bus.o_status, 32'h0);
    for (int i = 0; i < 3; i++) begin
      step;
      chk("dbl no_retrig", 32'(bus.o_busy), 32'd0);
      chk("dbl data_kept", 32'(bus.o_lcd_data), 32'h55);
    end

    // Single toggle while busy queues exactly one follow-up transaction
    start(1'b1, 8'h66);
    measure("single", 12, 1'b1, 8'h66, 2);
    chk("single status", bus.o_status, 32'h1);
    measure("second", 12, 1'b0, 8'hFF, 0);
    chk("second status", bus.o_status, 32'h0);

    start(1'b0, 8'h30);
    measure("pwr", 12, 1'b0, 8'h30, 3);
    chk("pwr status", bus.o_status, 32'h1);
    chk("pwr on", 32'(bus.o_lcd_on), 32'd1);

    // Reset while EN is high
    start(1'b1, 8'h48);
    for (int i = 0; i < 10; i++) begin
      step;
      if (bus.o_lcd_en === 1'b1) break;
    end
    chk("mid en_reached", 32'(bus.o_lcd_en), 32'd1);
    i_reset = 1'b1;
    step;
    chk("midrst en",     32'(bus.o_lcd_en),   32'd0);
    chk("midrst data",   32'(bus.o_lcd_data), 32'd0);
    chk("midrst rs",     32'(bus.o_lcd_rs),   32'd0);
    chk("midrst on",     32'(bus.o_lcd_on),   32'd0);
    chk("midrst status", bus.o_status,        32'h2);
    i_reset = 1'b0;
    bus.i_lcd[10] = 1'b1;
    init_wait("reinit");
    measure("rerun", 12, 1'b1, 8'h48, 0);
    chk("rerun status", bus.o_status, 32'h1);
    chk("rerun on", 32'(bus.o_lcd_on), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/lcd_ctrl.md
Name: lcd_ctrl

Overview:
- Downstream consumer of the LSU LCD register (o_ph_lcd). Converts software-written command words into correctly timed HD44780-style write cycles on the physical LCD pins.
- Handles power-up delay, setup/enable/hold timing and per-command execution wait, so firmware only writes a word and polls busy.
- Exposes a status word that the team maps into the LSU load mux for polling.

Parameters:
- POWERUP_CYC, 750000, cycles to wait after reset before first transaction (15 ms at 50 MHz)
- SETUP_CYC, 2, cycles RS/DATA are stable before EN rises
- PULSE_CYC, 25, cycles EN is held high
- HOLD_CYC, 2, cycles RS/DATA are held after EN falls
- EXEC_CYC, 2000, post-write wait for normal commands/data (40 us)
- LONG_EXEC_CYC, 82000, post-write wait for clear/home commands (1.64 ms)
- All parameters are ≥1. Counter width is $clog2 of the largest parameter plus 1.

Ports:
- i_clk  in  1  system clock
- i_reset  in  1  synchronous, active-high reset
- i_lcd  in  32  LCD register from LSU: [31] power, [10] request toggle, [9] RS, [7:0] data; other bits ignored
- o_lcd_data  out  8  LCD data bus
- o_lcd_rs  out  1  register select
- o_lcd_rw  out  1  read/write, constant 0 (write only)
- o_lcd_en  out  1  enable strobe
- o_lcd_on  out  1  LCD power, registered copy of i_lcd[31]
- o_busy  out  1  high while a transaction or power-up wait is in progress
- o_status  out  32  {30'b0, o_busy, ack}; ack is the toggle value of the last completed request

Behaviour:
- Reset (sampled on i_clk rising edge while i_reset=1) forces the following, effective on that edge, including mid-transaction:
  - state=INIT, counter=0, ack=0, o_busy=1
  - o_lcd_en=0, o_lcd_rs=0, o_lcd_data=0, o_lcd_on=0
- Request rule: a request is pending when i_lcd[10] != ack. Sampling happens only in IDLE, so net double toggles during busy cancel out.
- INIT: count POWERUP_CYC cycles, then go to IDLE and drop o_busy. Pending requests wait.
- IDLE: o_busy=0. If a request is pending:
  - latch rs=i_lcd[9], data=i_lcd[7:0], req=i_lcd[10]
  - drive o_lcd_rs/o_lcd_data from the latches on the same edge, set o_busy=1, go to SETUP
- SETUP: EN=0 for SETUP_CYC cycles, then go to PULSE.
- PULSE: EN=1 for exactly PULSE_CYC cycles, then go to HOLD.
- HOLD: EN=0 for HOLD_CYC cycles; RS/DATA unchanged. Then go to WAIT.
- WAIT:
  - count LONG_EXEC_CYC if rs=0 and data[7:2]==0 and data!=0 (clear 0x01, home 0x02/0x03); otherwise count EXEC_CYC
  - on completion: ack<=req, o_busy<=0, go to IDLE
- Timing invariants:
  - o_busy is high for exactly SETUP+PULSE+HOLD+exec cycles per transaction
  - a new transaction may start on the edge immediately after returning to IDLE (one IDLE cycle minimum)
- Stability: o_lcd_rs/o_lcd_data change only on the IDLE->SETUP edge. Changes to i_lcd[9:0] during busy are ignored.
- o_lcd_on follows i_lcd[31] with 1-cycle latency in all states except during reset. Power changes do not abort the FSM.
- o_lcd_en is glitch-free (registered output).

Test Plan:
(Sim params: POWERUP=10, SETUP=2, PULSE=3, HOLD=2, EXEC=5, LONG=20.)
1. Power-up: release reset, toggle i_lcd[10]=1 with data 0x41 at cycle 2 -> o_busy high through cycle 10; transaction starts only after INIT ends; EN high 3 cycles; o_status=0x1 after 12 busy cycles.
2. Data write: RS=1, data=0x48, toggle -> o_lcd_data=0x48, rs=1 from the IDLE->SETUP edge; EN rises 2 cycles later, high 3, low; busy exactly 12 cycles; ack flips.
3. Long command: RS=0, data=0x01 -> busy exactly 27 cycles. Same with data=0x04 -> 12 cycles.
4. Interference: during busy change data to 0xFF and toggle twice -> pins keep the original data; no second transaction after completion. A single toggle instead -> second transaction starts 1 cycle after IDLE.
5. Reset mid-PULSE: assert i_reset while EN=1 -> next edge EN=0, data=0, o_status=0x2 (busy, ack 0); INIT repeats.
6. Power bit: toggle i_lcd[31] 0->1 while in WAIT -> o_lcd_on=1 one cycle later; transaction completes unaffected.
